// File: rtl/board_scanner.sv
// Sweeps the 4x4 board, converts tile values to exponents, and publishes a display array plus game status.
// Latency: scan_req in cycle 0 -> READ cycles 1..16, EVAL cycle 17, scan_done/status in cycle 18.
// Backpressure: none; scan_req is ignored while busy, and a request held through scan_done starts the next sweep.
module board_scanner #(
    parameter int DATA_W  = 17,
    parameter int WIN_EXP = 11
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESET,
    input  logic              scan_req,
    input  logic [DATA_W-1:0] data,
    output logic [1:0]        rd_row,
    output logic [1:0]        rd_col,
    input  logic [1:0]        tile_row,
    input  logic [1:0]        tile_col,
    output logic [4:0]        tile_exp,
    output logic              busy,
    output logic              scan_done,
    output logic              win,
    output logic              game_over,
    output logic [4:0]        max_exp,
    output logic [4:0]        empty_cnt,
    output logic              bad_tile
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EVAL = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       start;
    logic [3:0] idx;

    // Shadow collects the sweep in progress; display is what the renderer sees.
    logic [4:0] shadow  [16];
    logic [4:0] display [16];

    logic [4:0] acc_max;
    logic [4:0] acc_empty;

    logic [4:0] data_exp;
    logic       data_zero;
    logic       data_multi;
    logic       adj_eq;

    // The read address is the sweep index itself, so it is registered by construction.
    assign rd_row   = idx[3:2];
    assign rd_col   = idx[1:0];
    assign busy     = (state == S_READ) || (state == S_EVAL);
    assign tile_exp = display[{tile_row, tile_col}];

    // Priority encode the highest set bit; a zero tile maps to exponent 0.
    always_comb begin
        data_exp = 5'd0;
        for (int b = 0; b < DATA_W; b++) begin
            if (data[b]) begin
                data_exp = 5'(b);
            end
        end
    end

    assign data_zero  = (data == '0);
    assign data_multi = ((data & (data - {{(DATA_W-1){1'b0}}, 1'b1})) != '0);

    // Look for any equal orthogonal neighbour pair in the completed shadow array.
    always_comb begin
        adj_eq = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (shadow[r*4+c] == shadow[r*4+c+1]) begin
                    adj_eq = 1'b1;
                end
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (shadow[r*4+c] == shadow[(r+1)*4+c]) begin
                    adj_eq = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a request is only accepted from IDLE.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                if (scan_req) begin
                    start     = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (idx == 4'd15) begin
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sweep index: advances through READ and wraps back to 0 after the last cell.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            idx <= 4'd0;
        end else if (state == S_READ) begin
            idx <= idx + 4'd1;
        end else begin
            idx <= 4'd0;
        end
    end

    // Capture each cell into the shadow array and accumulate max/empty statistics.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= 5'd0;
            end
            acc_max   <= 5'd0;
            acc_empty <= 5'd0;
        end else if (start) begin
            acc_max   <= 5'd0;
            acc_empty <= 5'd0;
        end else if (state == S_READ) begin
            shadow[idx] <= data_exp;
            if (data_exp > acc_max) begin
                acc_max <= data_exp;
            end
            if (data_zero) begin
                acc_empty <= acc_empty + 5'd1;
            end
        end
    end

    // Malformed tile flag is sticky until reset.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            bad_tile <= 1'b0;
        end else if ((state == S_READ) && !data_zero && data_multi) begin
            bad_tile <= 1'b1;
        end
    end

    // Atomic commit of display array and status at the EVAL edge.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            for (int i = 0; i < 16; i++) begin
                display[i] <= 5'd0;
            end
            max_exp   <= 5'd0;
            empty_cnt <= 5'd0;
            win       <= 1'b0;
            game_over <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= (state == S_EVAL);
            if (state == S_EVAL) begin
                for (int i = 0; i < 16; i++) begin
                    display[i] <= shadow[i];
                end
                max_exp   <= acc_max;
                empty_cnt <= acc_empty;
                win       <= (acc_max >= 5'(WIN_EXP));
                game_over <= (acc_empty == 5'd0) && !adj_eq;
            end
        end
    end

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: a small board memory answers the read port combinationally.
// Latency: checks the 18-cycle request-to-status timing and busy window on every sweep.
// Backpressure: exercises ignored and back-to-back requests plus reset during a sweep.
module tb_board_scanner;

    logic        CLK100MHZ = 1'b0;
    logic        CPU_RESET;
    logic        scan_req;
    logic [16:0] data;
    logic [1:0]  rd_row;
    logic [1:0]  rd_col;
    logic [1:0]  tile_row;
    logic [1:0]  tile_col;
    logic [4:0]  tile_exp;
    logic        busy;
    logic        scan_done;
    logic        win;
    logic        game_over;
    logic [4:0]  max_exp;
    logic [4:0]  empty_cnt;
    logic        bad_tile;

    logic [16:0] board [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    assign data = board[{rd_row, rd_col}];

    board_scanner #(.DATA_W(17), .WIN_EXP(11)) dut (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESET (CPU_RESET),
        .scan_req  (scan_req),
        .data      (data),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .tile_row  (tile_row),
        .tile_col  (tile_col),
        .tile_exp  (tile_exp),
        .busy      (busy),
        .scan_done (scan_done),
        .win       (win),
        .game_over (game_over),
        .max_exp   (max_exp),
        .empty_cnt (empty_cnt),
        .bad_tile  (bad_tile)
    );

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic w, input logic go,
                                input logic [4:0] mx, input logic [4:0] em, input logic bd);
        check({tag, ".win"},       {31'd0, win},       {31'd0, w});
        check({tag, ".game_over"}, {31'd0, game_over}, {31'd0, go});
        check({tag, ".max_exp"},   {27'd0, max_exp},   {27'd0, mx});
        check({tag, ".empty_cnt"}, {27'd0, empty_cnt}, {27'd0, em});
        check({tag, ".bad_tile"},  {31'd0, bad_tile},  {31'd0, bd});
    endtask

    task automatic check_tile(input string tag, input int r, input int c, input logic [4:0] exp);
        tile_row = 2'(r);
        tile_col = 2'(c);
        #1;
        check(tag, {27'd0, tile_exp}, {27'd0, exp});
    endtask

    // Counts display entries outside skip_mask that are not zero.
    task automatic check_zero_tiles(input string tag, input logic [15:0] skip_mask);
        int nz;
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            tile_row = 2'(i / 4);
            tile_col = 2'(i % 4);
            #1;
            if (!skip_mask[i] && tile_exp !== 5'd0) nz++;
        end
        check(tag, nz, 0);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 16; i++) board[i] = 17'd0;
    endtask

    task automatic apply_reset();
        CPU_RESET = 1'b1;
        scan_req  = 1'b0;
        step();
        step();
        CPU_RESET = 1'b0;
    endtask

    // One full sweep from a single-cycle request; optionally peeks tile (3,3) mid-READ.
    task automatic run_scan(input string tag, input bit peek, input logic [4:0] peek_exp);
        int bad_cyc;
        bad_cyc  = 0;
        scan_req = 1'b1;
        step();
        scan_req = 1'b0;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            if (!busy || scan_done) bad_cyc++;
            if (peek && cyc == 5) check_tile({tag, ".peek_during_read"}, 3, 3, peek_exp);
            if (cyc < 17) step();
        end
        check({tag, ".busy_window"}, bad_cyc, 0);
        step();
        check({tag, ".scan_done_c18"}, {31'd0, scan_done}, 32'd1);
        check({tag, ".busy_c18"}, {31'd0, busy}, 32'd0);
        step();
        check({tag, ".scan_done_pulse"}, {31'd0, scan_done}, 32'd0);
    endtask

    initial begin
        int n_done;
        int first_done;
        logic busy19;

        CPU_RESET = 1'b1;
        scan_req  = 1'b0;
        tile_row  = 2'd0;
        tile_col  = 2'd0;
        clear_board();

        // Reset state
        apply_reset();
        check_status("reset", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.scan_done", {31'd0, scan_done}, 32'd0);
        check("reset.rd_addr", {28'd0, rd_row, rd_col}, 32'd0);
        check_zero_tiles("reset.tiles", 16'h0000);

        // Sparse board: 2 at (0,0), 4 at (3,3)
        board[0]  = 17'd2;
        board[15] = 17'd4;
        run_scan("sparse", 1'b0, 5'd0);
        check_tile("sparse.t00", 0, 0, 5'd1);
        check_tile("sparse.t33", 3, 3, 5'd2);
        check_zero_tiles("sparse.others", 16'h8001);
        check_status("sparse", 1'b0, 1'b0, 5'd2, 5'd14, 1'b0);

        // Checkerboard 2/4; tile (3,3) holds 2 from the previous scan while reading
        for (int i = 0; i < 16; i++) board[i] = (((i / 4) + (i % 4)) % 2 == 1) ? 17'd4 : 17'd2;
        run_scan("checker", 1'b1, 5'd2);
        check_tile("checker.t33", 3, 3, 5'd1);
        check_tile("checker.t21", 2, 1, 5'd2);
        check_status("checker", 1'b0, 1'b1, 5'd2, 5'd0, 1'b0);

        // (2,1) made equal to (2,2) -> a merge exists
        board[9] = 17'd2;
        run_scan("checker_eq", 1'b0, 5'd0);
        check_tile("checker_eq.t21", 2, 1, 5'd1);
        check_status("checker_eq", 1'b0, 1'b0, 5'd2, 5'd0, 1'b0);

        // Win and extremes
        clear_board();
        board[6] = 17'd2048;
        run_scan("win2048", 1'b0, 5'd0);
        check_tile("win2048.t12", 1, 2, 5'd11);
        check_status("win2048", 1'b1, 1'b0, 5'd11, 5'd15, 1'b0);

        board[3] = 17'd65536;
        run_scan("max65536", 1'b0, 5'd0);
        check_tile("max65536.t03", 0, 3, 5'd16);
        check_status("max65536", 1'b1, 1'b0, 5'd16, 5'd14, 1'b0);

        clear_board();
        board[5] = 17'd1024;
        run_scan("nowin1024", 1'b0, 5'd0);
        check_tile("nowin1024.t11", 1, 1, 5'd10);
        check_status("nowin1024", 1'b0, 1'b0, 5'd10, 5'd15, 1'b0);

        // Malformed tile and sticky flag
        clear_board();
        board[10] = 17'd6;
        run_scan("bad6", 1'b0, 5'd0);
        check_tile("bad6.t22", 2, 2, 5'd2);
        check_status("bad6", 1'b0, 1'b0, 5'd2, 5'd15, 1'b1);

        board[10] = 17'd4;
        run_scan("clean_after_bad", 1'b0, 5'd0);
        check("clean_after_bad.bad_tile", {31'd0, bad_tile}, 32'd1);

        apply_reset();
        check("reset_clears_bad", {31'd0, bad_tile}, 32'd0);
        check_tile("reset_clears_tile", 2, 2, 5'd0);

        // Reset asserted in cycle 8 of a sweep
        for (int i = 0; i < 16; i++) board[i] = 17'd2;
        scan_req = 1'b1;
        step();
        scan_req = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check("midreset.rd_addr_c8", {28'd0, rd_row, rd_col}, {28'd0, 2'd1, 2'd3});
        CPU_RESET = 1'b1;
        step();
        CPU_RESET = 1'b0;
        check("midreset.busy_c9", {31'd0, busy}, 32'd0);
        check("midreset.rd_addr_c9", {28'd0, rd_row, rd_col}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (scan_done) n_done++;
        end
        check("midreset.no_done", n_done, 0);
        check_zero_tiles("midreset.tiles", 16'h0000);
        check("midreset.empty_cnt", {27'd0, empty_cnt}, 32'd0);

        // scan_req held high for cycles 0..30
        n_done     = 0;
        first_done = -1;
        busy19     = 1'b0;
        scan_req   = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (cyc == 31) scan_req = 1'b0;
            if (cyc == 19) busy19 = busy;
            if (scan_done && cyc <= 30) begin
                n_done++;
                if (first_done < 0) first_done = cyc;
            end
        end
        check("hold.one_done", n_done, 1);
        check("hold.done_cycle", first_done, 18);
        check("hold.read_c19", {31'd0, busy19}, 32'd1);
        check("hold.idle_after", {31'd0, busy}, 32'd0);
        check_status("hold", 1'b0, 1'b0, 5'd1, 5'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
